// File: rtl/irq_arbiter_if.sv
// ============================================================================
// irq_arbiter_if : trap request/ack/ret handshake between irq_arbiter and trap_ctrl  (rev 1.0)
// ============================================================================
`default_nettype none

interface irq_arbiter_if #(
  parameter int VEC_W = 6
) ();
  logic             o_trap_vld;
  logic [VEC_W-1:0] o_trapvec_id;
  logic             i_trap_ack;
  logic             i_trap_ret;

  // master = arbiter (request side), slave = trap_ctrl (service side)
  modport master (
    output o_trap_vld,
    output o_trapvec_id,
    input  i_trap_ack,
    input  i_trap_ret
  );

  modport slave (
    input  o_trap_vld,
    input  o_trapvec_id,
    output i_trap_ack,
    output i_trap_ret
  );
endinterface

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// irq_arbiter : synchronise platform IRQs, latch pending, fixed-priority single trap in flight  (rev 1.0)
// ============================================================================
`default_nettype none

module irq_arbiter #(
  parameter int          NSRC      = 16,
  parameter logic [15:0] EDGE_MASK = 16'h0000,
  parameter int          XLEN      = 32,
  parameter int          VEC_W     = 6
) (
  input  wire logic            i_clk,
  input  wire logic            i_rstn,
  input  wire logic [NSRC-1:0] i_irq,
  input  wire logic [XLEN-1:0] i_csr_mstatus,
  input  wire logic [XLEN-1:0] i_csr_mie,
  output logic      [XLEN-1:0] o_csr_mip,
  output logic                 o_busy,
  irq_arbiter_if.master        trap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NSRC-1:0]  r_s1;
  logic [NSRC-1:0]  r_s2;
  logic [NSRC-1:0]  r_s3;
  logic [NSRC-1:0]  r_pending;
  logic [NSRC-1:0]  w_pend_nxt;
  logic [NSRC-1:0]  w_ack_clr;
  logic [NSRC-1:0]  w_elig;
  logic             w_any;
  logic [VEC_W-1:0] w_win_id;
  logic             w_ack_take;
  logic             r_trap_vld;
  logic             w_vld_nxt;
  logic [VEC_W-1:0] r_trapvec_id;
  logic [VEC_W-1:0] w_id_nxt;
  logic [XLEN-1:0]  w_mip;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Only an ack actually taken in REQ clears the edge-pending bit of the id on the bus
  assign w_ack_take = (r_state == S_REQ) && trap.i_trap_ack;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign w_ack_clr[k] = w_ack_take && (r_trapvec_id == VEC_W'(16 + k));
    if (EDGE_MASK[k]) begin : g_edge
      assign w_pend_nxt[k] = (r_s2[k] & ~r_s3[k]) | (r_pending[k] & ~w_ack_clr[k]);
    end else begin : g_level
      assign w_pend_nxt[k] = r_s2[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  assign w_elig = r_pending & i_csr_mie[16 +: NSRC] & {NSRC{i_csr_mstatus[3]}};
  assign w_any  = |w_elig;

  // Descending scan so the lowest eligible index is the one left standing
  always_comb begin
    w_win_id = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_win_id = VEC_W'(16 + k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_trap_vld   <= 1'b0;
      r_trapvec_id <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_trap_vld   <= w_vld_nxt;
      r_trapvec_id <= w_id_nxt;
    end
  end

  // A request, once issued, is held until ack regardless of what happens to its source
  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = r_trap_vld;
    w_id_nxt    = r_trapvec_id;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_vld_nxt   = 1'b1;
          w_id_nxt    = w_win_id;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (trap.i_trap_ack) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = S_SVC;
        end
      end
      S_SVC: begin
        if (trap.i_trap_ret) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_vld_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_mip              = '0;
    w_mip[16 +: NSRC]  = r_pending;
  end

  assign o_csr_mip         = w_mip;
  assign o_busy            = (r_state != S_IDLE);
  assign trap.o_trap_vld   = r_trap_vld;
  assign trap.o_trapvec_id = r_trapvec_id;

  // Bits of the CSR inputs outside MIE / mie[16+:NSRC] are intentionally ignored
  logic w_unused;
  assign w_unused = &{1'b0, i_csr_mstatus, i_csr_mie, r_s3, w_ack_clr};

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// tb_irq_arbiter : directed scenarios plus randomized run against a sample-history reference model  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_irq_arbiter;
  localparam int          NSRC  = 16;
  localparam logic [15:0] EDGE  = 16'h0001;
  localparam int          XLEN  = 32;
  localparam int          VEC_W = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] irq = '0;
  logic [31:0] mie = '0;
  logic [31:0] mstatus = '0;
  logic [31:0] mip;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;

  irq_arbiter_if #(.VEC_W(VEC_W)) bus ();

  irq_arbiter #(.NSRC(NSRC), .EDGE_MASK(EDGE), .XLEN(XLEN), .VEC_W(VEC_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_irq(irq), .i_csr_mstatus(mstatus),
    .i_csr_mie(mie), .o_csr_mip(mip), .o_busy(busy), .trap(bus)
  );

  always #5 clk = ~clk;

  // Reference: pending derived from the raw-line sample history; one trap owner at a time
  logic [3:0][15:0] m_hist;
  logic [15:0]      m_pend;
  int               m_phase;   // 0 free, 1 requested, 2 in service
  logic             m_vld;
  logic [5:0]       m_id;

  function automatic int f_lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] f_clr(input int phase, input logic ack, input logic [5:0] id);
    if (phase == 1 && ack) return 16'h1 << (id - 6'd16);
    return 16'h0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_hist <= '0; m_pend <= '0; m_phase <= 0; m_vld <= 1'b0; m_id <= '0;
    end else begin
      m_hist <= {m_hist[2:0], irq};
      m_pend <= (~EDGE & m_hist[1]) |
                (EDGE & ((m_hist[1] & ~m_hist[2]) | (m_pend & ~f_clr(m_phase, bus.i_trap_ack, m_id))));
      case (m_phase)
        0: if (f_lowest(m_pend & mie[31:16] & {16{mstatus[3]}}) >= 0) begin
             m_vld   <= 1'b1;
             m_id    <= 6'(16 + f_lowest(m_pend & mie[31:16] & {16{mstatus[3]}}));
             m_phase <= 1;
           end
        1: if (bus.i_trap_ack) begin m_vld <= 1'b0; m_phase <= 2; end
        2: if (bus.i_trap_ret) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    irq = '0; mie = '0; mstatus = '0;
    bus.i_trap_ack = 1'b0; bus.i_trap_ret = 1'b0;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    irq = '0; mie = '0; mstatus = '0;
    bus.i_trap_ack = 1'b0; bus.i_trap_ret = 1'b0;
    rstn = 1'b0;
    tick(2);
    n_checks++; if (bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b exp 0", bus.o_trap_vld); end
    n_checks++; if (bus.o_trapvec_id !== 6'd0) begin n_fail++; $display("FAIL rst_id: got %0d exp 0", bus.o_trapvec_id); end
    n_checks++; if (mip !== 32'h0) begin n_fail++; $display("FAIL rst_mip: got %h exp 0", mip); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    rstn = 1'b1; mie = 32'h1 << 19; mstatus = 32'h8; irq[3] = 1'b1;
    tick(3);
    n_checks++; if (bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b exp 0", bus.o_trap_vld); end
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd19) begin n_fail++; $display("FAIL lat4_req: vld %b id %0d exp 1/19", bus.o_trap_vld, bus.o_trapvec_id); end
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.o_trap_vld !== 1'b0 || bus.o_trapvec_id !== 6'd0) begin n_fail++; $display("FAIL midreq_rst_trap: vld %b id %0d exp 0/0", bus.o_trap_vld, bus.o_trapvec_id); end
    n_checks++; if (busy !== 1'b0 || mip !== 32'h0) begin n_fail++; $display("FAIL midreq_rst_state: busy %b mip %h exp 0/0", busy, mip); end
    tick();
    rstn = 1'b1;
    tick(3);
    n_checks++; if (bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL relat_early: got %b exp 0", bus.o_trap_vld); end
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd19) begin n_fail++; $display("FAIL relat_req: vld %b id %0d exp 1/19", bus.o_trap_vld, bus.o_trapvec_id); end
  endtask

  task automatic test_priority();
    int t;
    do_reset();
    mie = (32'h1 << 18) | (32'h1 << 21); mstatus = 32'h8; irq[2] = 1'b1; irq[5] = 1'b1;
    t = 0; while (bus.o_trap_vld !== 1'b1 && t < 8) begin tick(); t++; end
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd18) begin n_fail++; $display("FAIL prio_first: vld %b id %0d exp 1/18", bus.o_trap_vld, bus.o_trapvec_id); end
    n_checks++; if (mip !== 32'h0024_0000) begin n_fail++; $display("FAIL prio_mip: got %h exp 00240000", mip); end
    irq[2] = 1'b0; bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    n_checks++; if (bus.o_trap_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL prio_svc: vld %b busy %b exp 0/1", bus.o_trap_vld, busy); end
    tick(4);
    n_checks++; if (mip !== 32'h0020_0000) begin n_fail++; $display("FAIL prio_mip_drop: got %h exp 00200000", mip); end
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL prio_idle: busy %b vld %b exp 0/0", busy, bus.o_trap_vld); end
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd21) begin n_fail++; $display("FAIL prio_second: vld %b id %0d exp 1/21", bus.o_trap_vld, bus.o_trapvec_id); end
    irq[5] = 1'b0; bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    tick(4);
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    tick(2);
    n_checks++; if (busy !== 1'b0 || bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL prio_done: busy %b vld %b exp 0/0", busy, bus.o_trap_vld); end
  endtask

  task automatic test_edge_pulse();
    do_reset();
    mie = 32'h1 << 16; mstatus = 32'h8;
    irq[0] = 1'b1; tick(); irq[0] = 1'b0;
    tick(2);
    n_checks++; if (mip[16] !== 1'b1 || bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL edge_pend: mip16 %b vld %b exp 1/0", mip[16], bus.o_trap_vld); end
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd16) begin n_fail++; $display("FAIL edge_req: vld %b id %0d exp 1/16", bus.o_trap_vld, bus.o_trapvec_id); end
    tick(2);
    n_checks++; if (mip[16] !== 1'b1) begin n_fail++; $display("FAIL edge_hold: mip16 %b exp 1", mip[16]); end
    bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    n_checks++; if (mip[16] !== 1'b0 || bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL edge_clr: mip16 %b vld %b exp 0/0", mip[16], bus.o_trap_vld); end
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL edge_norepeat: vld %b exp 0", bus.o_trap_vld); end
    irq[0] = 1'b1; tick(); irq[0] = 1'b0;
    tick(3);
    n_checks++; if (bus.o_trap_vld !== 1'b1) begin n_fail++; $display("FAIL edge_req2: vld %b exp 1", bus.o_trap_vld); end
    irq[0] = 1'b1; tick(); irq[0] = 1'b0;
    tick();
    bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    n_checks++; if (mip[16] !== 1'b1 || bus.o_trap_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL edge_setwins: mip16 %b vld %b busy %b exp 1/0/1", mip[16], bus.o_trap_vld, busy); end
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd16) begin n_fail++; $display("FAIL edge_req3: vld %b id %0d exp 1/16", bus.o_trap_vld, bus.o_trapvec_id); end
  endtask

  task automatic test_masking();
    do_reset();
    mie = 32'h1 << 17; mstatus = 32'h0; irq[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL mask_novld: cyc %0d vld %b exp 0", i, bus.o_trap_vld); end
    end
    n_checks++; if (mip !== 32'h0002_0000) begin n_fail++; $display("FAIL mask_mip: got %h exp 00020000", mip); end
    mstatus = 32'h8; tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd17) begin n_fail++; $display("FAIL mask_enable: vld %b id %0d exp 1/17", bus.o_trap_vld, bus.o_trapvec_id); end
  endtask

  task automatic test_committed();
    int t;
    do_reset();
    mie = 32'h1 << 20; mstatus = 32'h8; irq[4] = 1'b1;
    t = 0; while (bus.o_trap_vld !== 1'b1 && t < 8) begin tick(); t++; end
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd20) begin n_fail++; $display("FAIL commit_req: vld %b id %0d exp 1/20", bus.o_trap_vld, bus.o_trapvec_id); end
    irq[4] = 1'b0; mie = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd20) begin n_fail++; $display("FAIL commit_hold: cyc %0d vld %b id %0d exp 1/20", i, bus.o_trap_vld, bus.o_trapvec_id); end
    end
    n_checks++; if (mip !== 32'h0) begin n_fail++; $display("FAIL commit_mip: got %h exp 0", mip); end
    bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    n_checks++; if (bus.o_trap_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL commit_ack: vld %b busy %b exp 0/1", bus.o_trap_vld, busy); end
  endtask

  task automatic test_no_nesting();
    int t;
    do_reset();
    mie = (32'h1 << 21) | (32'h1 << 16); mstatus = 32'h8; irq[5] = 1'b1;
    t = 0; while (bus.o_trap_vld !== 1'b1 && t < 8) begin tick(); t++; end
    n_checks++; if (bus.o_trapvec_id !== 6'd21) begin n_fail++; $display("FAIL nest_first: id %0d exp 21", bus.o_trapvec_id); end
    bus.i_trap_ack = 1'b1; irq[5] = 1'b0; tick(); bus.i_trap_ack = 1'b0;
    irq[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.o_trap_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nest_block: cyc %0d vld %b busy %b exp 0/1", i, bus.o_trap_vld, busy); end
    end
    n_checks++; if (mip[16] !== 1'b1) begin n_fail++; $display("FAIL nest_mip16: got %b exp 1", mip[16]); end
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    n_checks++; if (bus.o_trap_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nest_ret1: vld %b busy %b exp 0/0", bus.o_trap_vld, busy); end
    tick();
    n_checks++; if (bus.o_trap_vld !== 1'b1 || bus.o_trapvec_id !== 6'd16) begin n_fail++; $display("FAIL nest_ret2: vld %b id %0d exp 1/16", bus.o_trap_vld, bus.o_trapvec_id); end
    bus.i_trap_ack = 1'b1; bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ack = 1'b0; bus.i_trap_ret = 1'b0;
    n_checks++; if (busy !== 1'b1 || bus.o_trap_vld !== 1'b0 || mip[16] !== 1'b0) begin n_fail++; $display("FAIL ackret_svc: busy %b vld %b mip16 %b exp 1/0/0", busy, bus.o_trap_vld, mip[16]); end
    bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL svc_stray_ack: busy %b exp 1", busy); end
    bus.i_trap_ret = 1'b1; tick(); bus.i_trap_ret = 1'b0;
    tick(2);
    n_checks++; if (busy !== 1'b0 || bus.o_trap_vld !== 1'b0) begin n_fail++; $display("FAIL nest_end: busy %b vld %b exp 0/0", busy, bus.o_trap_vld); end
    irq[0] = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    tick();
    for (int c = 0; c < 3000; c++) begin
      n_checks++; if (bus.o_trap_vld !== m_vld) begin n_fail++; $display("FAIL rnd_vld: cyc %0d got %b exp %b", c, bus.o_trap_vld, m_vld); end
      n_checks++; if (bus.o_trapvec_id !== m_id) begin n_fail++; $display("FAIL rnd_id: cyc %0d got %0d exp %0d", c, bus.o_trapvec_id, m_id); end
      n_checks++; if (mip !== {m_pend, 16'h0}) begin n_fail++; $display("FAIL rnd_mip: cyc %0d got %h exp %h", c, mip, {m_pend, 16'h0}); end
      n_checks++; if (busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy: cyc %0d got %b exp %b", c, busy, (m_phase != 0)); end
      irq = irq ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) mie = {16'($urandom), 16'h0};
      mstatus = ($urandom_range(0, 9) != 0) ? 32'h8 : 32'h0;
      bus.i_trap_ack = bus.o_trap_vld ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      bus.i_trap_ret = (busy && !bus.o_trap_vld) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      rstn = ($urandom_range(0, 499) != 0);
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  initial begin
    bus.i_trap_ack = 1'b0;
    bus.i_trap_ret = 1'b0;
    test_reset();
    test_priority();
    test_edge_pulse();
    test_masking();
    test_committed();
    test_no_nesting();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Collects NSRC external platform interrupt lines and synchronises them.
- Latches them into pending bits and picks one winner by fixed priority.
- Drives the single trap request (i_trap_vld / i_trapvec_id) into trap_ctrl.
- Holds the trap path exclusively from request through ack to mret, so only one interrupt is ever in flight (no nesting); also exports the platform bits of mip.

Parameters:
- NSRC, 16: number of interrupt sources, 1..16.
- EDGE_MASK, 16'h0000: bit k=1 makes source k edge-triggered; bit k=0 makes it level-triggered.
- XLEN, 32: CSR width.
- VEC_W, 6: trap vector id width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_irq  in  NSRC  raw interrupt lines, asynchronous to i_clk.
- i_csr_mstatus  in  XLEN  bit 3 = MIE, global enable.
- i_csr_mie  in  XLEN  bit 16+k enables source k.
- o_csr_mip  out  XLEN  bit 16+k = pending[k]; all other bits 0.
- o_trap_vld  out  1  trap request to trap_ctrl.
- o_trapvec_id  out  VEC_W  16+k of the winning source.
- i_trap_ack  in  1  trap_ctrl has taken the trap (mepc/mcause written).
- i_trap_ret  in  1  one-cycle pulse when mret retires.
- o_busy  out  1  high in REQ and SVC states.

Behaviour:
- Reset: all registers clear asynchronously on i_rstn low: sync stages, pending, state=IDLE, o_trap_vld=0, o_trapvec_id=0, o_busy=0, o_csr_mip=0. Any in-flight request or service is abandoned.
- Synchroniser: two flops per line (s1, s2). Edge detect uses an s2 delay flop (s3).
- Pending, level source: pending[k] <= s2[k].
- Pending, edge source: set on s2 & ~s3; cleared when i_trap_ack is taken for source k. Set wins when a new edge coincides with the clear.
- Eligible set: pending & mie[16+:NSRC], qualified by mstatus[3]. Winner = lowest index eligible.
- FSM IDLE: when any source is eligible, register o_trapvec_id=16+winner and o_trap_vld=1, then go to REQ. The decision is registered, so o_trap_vld rises one cycle after pending.
- FSM REQ: o_trap_vld and o_trapvec_id are held stable until i_trap_ack. The request is committed and never withdrawn, even if the level drops or mie/MIE clears; trap_ctrl is then servicing a stale source, and software tolerates this. On ack: o_trap_vld=0 the next cycle, clear the edge-pending bit of that id, go to SVC.
- FSM SVC: no new requests are issued. On i_trap_ret go to IDLE. Arbitration resumes in the cycle after IDLE is entered, so back-to-back service takes a minimum of 2 cycles from ret to the next o_trap_vld.
- Protocol errors: i_trap_ack outside REQ and i_trap_ret outside SVC are ignored.
- Simultaneous i_trap_ack and i_trap_ret in REQ: take the ack only and go to SVC.
- Latency: i_irq rises before edge E0 → s1 after E0 → s2 after E1 → pending after E2 → o_trap_vld high after E3. This gives a 4-edge request latency from IDLE with the source enabled.
- o_csr_mip: registered copy of pending, placed at bits 16+k. It updates in the same cycle as pending and is independent of the FSM.
- o_busy = (state != IDLE).

Test Plan:
- Reset mid-REQ: EDGE_MASK=0, irq[3] high, mie=1<<19, MIE=1, assert i_rstn low while o_trap_vld=1 → all outputs 0 immediately. After release with irq[3] still high, o_trap_vld reasserts 4 edges later with id 19.
- Priority: level sources 2 and 5 both high, both enabled → id 18 first. After ack + ret with irq[2] dropped → id 21. After its ret with nothing pending → o_busy=0.
- Edge pulse: EDGE_MASK bit0=1, one-cycle irq[0] pulse → o_csr_mip[16]=1 until ack, then 0. A second pulse arriving in the same cycle as the ack leaves mip[16]=1.
- Masking: irq[1] high but MIE=0 → o_trap_vld stays 0 and mip[17]=1. Set MIE → o_trap_vld the next cycle with id 17.
- Committed request: in REQ with id 20, drop irq[4] and clear mie → o_trap_vld and id 20 held until ack.
- No nesting: in SVC, raise irq[0] enabled → no request until i_trap_ret. Then o_trap_vld with id 16 exactly 2 cycles after the ret pulse. Ack and ret in the same REQ cycle → state SVC.
